id_exe_stage_reg: RTL and testbench



---
 rtl/arm_pkg.sv | 24 ++
 rtl/pipe_field_reg.sv | 24 ++
 rtl/id_exe_stage_reg.sv | 140 ++++++++++++++
 tb/tb_id_exe_stage_reg.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared widths, ALU command encodings and reset constants for the ARM-style
// pipeline; imported by every pipeline-register file.
package arm_pkg;

    localparam int REG_IDX_W  = 4;
    localparam int EXE_CMD_W  = 4;
    localparam int SHIFT_OP_W = 12;
    localparam int DATA_W     = 32;

    localparam logic [EXE_CMD_W-1:0] EXE_CMD_NOP = 4'b0000;
    localparam logic [EXE_CMD_W-1:0] EXE_CMD_MOV = 4'b0001;
    localparam logic [EXE_CMD_W-1:0] EXE_CMD_MVN = 4'b1001;
    localparam logic [EXE_CMD_W-1:0] EXE_CMD_ADD = 4'b0010;
    localparam logic [EXE_CMD_W-1:0] EXE_CMD_ADC = 4'b0011;
    localparam logic [EXE_CMD_W-1:0] EXE_CMD_SUB = 4'b0100;
    localparam logic [EXE_CMD_W-1:0] EXE_CMD_SBC = 4'b0101;
    localparam logic [EXE_CMD_W-1:0] EXE_CMD_AND = 4'b0110;
    localparam logic [EXE_CMD_W-1:0] EXE_CMD_ORR = 4'b0111;
    localparam logic [EXE_CMD_W-1:0] EXE_CMD_EOR = 4'b1000;

    // Every bit of the bubble counter resets to this value.
    localparam logic BUBBLE_RST_BIT = 1'b0;

endpackage

// File: rtl/pipe_field_reg.sv
// W-bit pipeline field register: async active-low reset, flush-to-zero,
// freeze-hold, else load. Ports: clk, rst_n, flush_i, freeze_i, d_i -> q_o.
module pipe_field_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         freeze_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_o <= '0;
        end else if (flush_i) begin
            q_o <= '0;
        end else if (!freeze_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register with freeze/flush and a saturating bubble counter.
// Ports: decoded fields *_in -> *_out, valid, mem_en_out, bubble_cnt.
// Macro ID_EXE_FORWARDING_EN: registers src1/src2 for the forwarding unit.
module id_exe_stage_reg
    import arm_pkg::*;
#(
    parameter int BUBBLE_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    freeze,
    input  logic                    flush,
    input  logic                    valid_in,
    input  logic [DATA_W-1:0]       pc_in,
    input  logic [DATA_W-1:0]       val_rn_in,
    input  logic [DATA_W-1:0]       val_rm_in,
    input  logic [SHIFT_OP_W-1:0]   shifter_operand_in,
    input  logic                    imm_in,
    input  logic [23:0]             signed_imm24_in,
    input  logic [EXE_CMD_W-1:0]    exe_cmd_in,
    input  logic [REG_IDX_W-1:0]    dest_in,
    input  logic                    wb_en_in,
    input  logic                    mem_r_en_in,
    input  logic                    mem_w_en_in,
    input  logic                    b_in,
    input  logic                    s_in,
    input  logic [3:0]              status_in,
    input  logic [REG_IDX_W-1:0]    src1_in,
    input  logic [REG_IDX_W-1:0]    src2_in,
    output logic                    valid_out,
    output logic [DATA_W-1:0]       pc_out,
    output logic [DATA_W-1:0]       val_rn_out,
    output logic [DATA_W-1:0]       val_rm_out,
    output logic [SHIFT_OP_W-1:0]   shifter_operand_out,
    output logic                    imm_out,
    output logic [23:0]             signed_imm24_out,
    output logic [EXE_CMD_W-1:0]    exe_cmd_out,
    output logic [REG_IDX_W-1:0]    dest_out,
    output logic                    wb_en_out,
    output logic                    mem_r_en_out,
    output logic                    mem_w_en_out,
    output logic                    b_out,
    output logic                    s_out,
    output logic [3:0]              status_out,
    output logic [REG_IDX_W-1:0]    src1_out,
    output logic [REG_IDX_W-1:0]    src2_out,
    output logic                    mem_en_out,
    output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);

    localparam int INS_W = 1 + 24 + EXE_CMD_W + REG_IDX_W + SHIFT_OP_W;

    logic [BUBBLE_CNT_W-1:0] cnt_q, cnt_d;

    pipe_field_reg #(.W(6)) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (flush),
        .freeze_i (freeze),
        .d_i      ({valid_in, wb_en_in, mem_r_en_in,
                    mem_w_en_in, b_in, s_in}),
        .q_o      ({valid_out, wb_en_out, mem_r_en_out,
                    mem_w_en_out, b_out, s_out})
    );

    pipe_field_reg #(.W(DATA_W)) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (flush),
        .freeze_i (freeze),
        .d_i      (pc_in),
        .q_o      (pc_out)
    );

    pipe_field_reg #(.W(2*DATA_W)) u_ops (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (flush),
        .freeze_i (freeze),
        .d_i      ({val_rn_in, val_rm_in}),
        .q_o      ({val_rn_out, val_rm_out})
    );

    pipe_field_reg #(.W(INS_W)) u_ins (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (flush),
        .freeze_i (freeze),
        .d_i      ({imm_in, signed_imm24_in, exe_cmd_in,
                    dest_in, shifter_operand_in}),
        .q_o      ({imm_out, signed_imm24_out, exe_cmd_out,
                    dest_out, shifter_operand_out})
    );

    pipe_field_reg #(.W(4)) u_status (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (flush),
        .freeze_i (freeze),
        .d_i      (status_in),
        .q_o      (status_out)
    );

`ifdef ID_EXE_FORWARDING_EN
    pipe_field_reg #(.W(2*REG_IDX_W)) u_src (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (flush),
        .freeze_i (freeze),
        .d_i      ({src1_in, src2_in}),
        .q_o      ({src1_out, src2_out})
    );
`else
    logic unused_src;
    assign unused_src = ^{src1_in, src2_in};
    assign src1_out   = '0;
    assign src2_out   = '0;
`endif

    assign mem_en_out = mem_r_en_out | mem_w_en_out;

    // Flush and freeze together still count as a single bubble.
    always_comb begin
        cnt_d = cnt_q;
        if ((flush || freeze) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {BUBBLE_CNT_W{BUBBLE_RST_BIT}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Directed table-driven bench for id_exe_stage_reg (4-bit bubble counter).
module tb_id_exe_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n, freeze, flush, valid_in;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic [11:0] shifter_operand_in;
    logic        imm_in;
    logic [23:0] signed_imm24_in;
    logic [3:0]  exe_cmd_in, dest_in, status_in, src1_in, src2_in;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in;
    logic        valid_out;
    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic [11:0] shifter_operand_out;
    logic        imm_out;
    logic [23:0] signed_imm24_out;
    logic [3:0]  exe_cmd_out, dest_out, status_out, src1_out, src2_out;
    logic        wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out;
    logic        mem_en_out;
    logic [3:0]  bubble_cnt;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    id_exe_stage_reg #(.BUBBLE_CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .valid_in(valid_in), .pc_in(pc_in), .val_rn_in(val_rn_in),
        .val_rm_in(val_rm_in), .shifter_operand_in(shifter_operand_in),
        .imm_in(imm_in), .signed_imm24_in(signed_imm24_in),
        .exe_cmd_in(exe_cmd_in), .dest_in(dest_in), .wb_en_in(wb_en_in),
        .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .b_in(b_in), .s_in(s_in), .status_in(status_in),
        .src1_in(src1_in), .src2_in(src2_in),
        .valid_out(valid_out), .pc_out(pc_out), .val_rn_out(val_rn_out),
        .val_rm_out(val_rm_out), .shifter_operand_out(shifter_operand_out),
        .imm_out(imm_out), .signed_imm24_out(signed_imm24_out),
        .exe_cmd_out(exe_cmd_out), .dest_out(dest_out),
        .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
        .mem_w_en_out(mem_w_en_out), .b_out(b_out), .s_out(s_out),
        .status_out(status_out), .src1_out(src1_out), .src2_out(src2_out),
        .mem_en_out(mem_en_out), .bubble_cnt(bubble_cnt)
    );

    typedef struct {
        logic        fl, fz, vld;
        logic [31:0] pc, rm;
        logic [11:0] sh;
        logic [3:0]  dst;
        logic        wb, mr, mw;
        logic        e_vld;
        logic [31:0] e_pc, e_rm;
        logic [11:0] e_sh;
        logic [3:0]  e_dst;
        logic        e_wb, e_men;
        logic [3:0]  e_cnt;
        logic        zchk;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(
        logic fl, logic fz, logic vld, logic [31:0] pc, logic [31:0] rm,
        logic [11:0] sh, logic [3:0] dst, logic wb, logic mr, logic mw,
        logic e_vld, logic [31:0] e_pc, logic [31:0] e_rm,
        logic [11:0] e_sh, logic [3:0] e_dst, logic e_wb, logic e_men,
        logic [3:0] e_cnt, logic zchk);
        vec_t v;
        v.fl = fl; v.fz = fz; v.vld = vld; v.pc = pc; v.rm = rm;
        v.sh = sh; v.dst = dst; v.wb = wb; v.mr = mr; v.mw = mw;
        v.e_vld = e_vld; v.e_pc = e_pc; v.e_rm = e_rm; v.e_sh = e_sh;
        v.e_dst = e_dst; v.e_wb = e_wb; v.e_men = e_men;
        v.e_cnt = e_cnt; v.zchk = zchk;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(vec_t v);
        flush = v.fl; freeze = v.fz; valid_in = v.vld;
        pc_in = v.pc; val_rm_in = v.rm; shifter_operand_in = v.sh;
        dest_in = v.dst; wb_en_in = v.wb;
        mem_r_en_in = v.mr; mem_w_en_in = v.mw;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, ".ctrl"},
            {27'd0, valid_out, wb_en_out, mem_r_en_out,
             mem_w_en_out, b_out, s_out}, 32'd0);
        chk({tag, ".pc"}, pc_out, 32'd0);
        chk({tag, ".rn"}, val_rn_out, 32'd0);
        chk({tag, ".rm"}, val_rm_out, 32'd0);
        chk({tag, ".ins"},
            {3'd0, imm_out, signed_imm24_out, exe_cmd_out},
            32'd0);
        chk({tag, ".sh_dst_st"},
            {12'd0, shifter_operand_out, dest_out, status_out},
            32'd0);
        chk({tag, ".src"}, {24'd0, src1_out, src2_out}, 32'd0);
        chk({tag, ".men"}, {31'd0, mem_en_out}, 32'd0);
    endtask

    initial begin
        logic [3:0] ecnt;
        rst_n = 1'b0; freeze = 0; flush = 0; valid_in = 0;
        pc_in = 0; val_rn_in = 32'hDEAD_BEEF; val_rm_in = 0;
        shifter_operand_in = 0; imm_in = 0; signed_imm24_in = 24'h123456;
        exe_cmd_in = 4'hA; dest_in = 0; status_in = 4'h5;
        wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
        b_in = 1; s_in = 1; src1_in = 4'd3; src2_in = 4'd7;

        tbl[0]  = mk(0,0,1, 32'h10,32'hF0,12'h1A3,4'd0,0,0,0,
                     1,32'h10,32'hF0,12'h1A3,4'd0,0,0,4'd0,0);
        tbl[1]  = mk(0,0,1, 32'h14,32'h1,12'h0,4'd5,0,0,0,
                     1,32'h14,32'h1,12'h0,4'd5,0,0,4'd0,0);
        tbl[2]  = mk(0,1,1, 32'h18,32'h2,12'h1,4'd9,0,0,0,
                     1,32'h14,32'h1,12'h0,4'd5,0,0,4'd1,0);
        tbl[3]  = mk(0,1,1, 32'h18,32'h2,12'h1,4'd9,0,0,0,
                     1,32'h14,32'h1,12'h0,4'd5,0,0,4'd2,0);
        tbl[4]  = mk(0,1,1, 32'h18,32'h2,12'h1,4'd9,0,0,0,
                     1,32'h14,32'h1,12'h0,4'd5,0,0,4'd3,0);
        tbl[5]  = mk(0,0,1, 32'h18,32'h2,12'h1,4'd9,0,0,0,
                     1,32'h18,32'h2,12'h1,4'd9,0,0,4'd3,0);
        tbl[6]  = mk(0,0,1, 32'h1C,32'h3,12'h2,4'd2,1,0,1,
                     1,32'h1C,32'h3,12'h2,4'd2,1,1,4'd3,0);
        tbl[7]  = mk(1,1,1, 32'h20,32'h4,12'h3,4'd3,1,1,1,
                     0,32'h0,32'h0,12'h0,4'd0,0,0,4'd4,1);
        tbl[8]  = mk(0,0,1, 32'h24,32'h5,12'h4,4'd1,0,1,0,
                     1,32'h24,32'h5,12'h4,4'd1,0,1,4'd4,0);
        tbl[9]  = mk(0,0,1, 32'h28,32'h6,12'h5,4'd1,0,0,0,
                     1,32'h28,32'h6,12'h5,4'd1,0,0,4'd4,0);
        tbl[10] = mk(0,0,1, 32'h2C,32'h7,12'h6,4'd1,0,0,1,
                     1,32'h2C,32'h7,12'h6,4'd1,0,1,4'd4,0);
        tbl[11] = mk(0,0,0, 32'h30,32'h8,12'h7,4'd4,1,0,0,
                     0,32'h30,32'h8,12'h7,4'd4,1,0,4'd4,0);
        tbl[12] = mk(0,1,1, 32'h34,32'h9,12'h8,4'd6,0,1,0,
                     0,32'h30,32'h8,12'h7,4'd4,1,0,4'd5,0);

        // Load something, bubble once, then reset asynchronously mid-cycle.
        step(); step();
        rst_n = 1'b1;
        valid_in = 1; pc_in = 32'h44; dest_in = 4'd7;
        wb_en_in = 1; mem_w_en_in = 1;
        step();
        freeze = 1;
        step();
        chk("pre_rst.pc", pc_out, 32'h44);
        chk("pre_rst.cnt", {28'd0, bubble_cnt}, 32'd1);
        #3 rst_n = 1'b0;
        #1 chk_zero("async_rst");
        chk("async_rst.cnt", {28'd0, bubble_cnt}, 32'd0);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i]);
            step();
            chk($sformatf("v%0d.valid", i), {31'd0, valid_out},
                {31'd0, tbl[i].e_vld});
            chk($sformatf("v%0d.pc", i), pc_out, tbl[i].e_pc);
            chk($sformatf("v%0d.rm", i), val_rm_out, tbl[i].e_rm);
            chk($sformatf("v%0d.sh", i), {20'd0, shifter_operand_out},
                {20'd0, tbl[i].e_sh});
            chk($sformatf("v%0d.dest", i), {28'd0, dest_out},
                {28'd0, tbl[i].e_dst});
            chk($sformatf("v%0d.wb", i), {31'd0, wb_en_out},
                {31'd0, tbl[i].e_wb});
            chk($sformatf("v%0d.mem_en", i), {31'd0, mem_en_out},
                {31'd0, tbl[i].e_men});
            chk($sformatf("v%0d.cnt", i), {28'd0, bubble_cnt},
                {28'd0, tbl[i].e_cnt});
            if (tbl[i].zchk) chk_zero($sformatf("v%0d", i));
        end

        // Hold flush for 20 cycles: counter must stick at 4'hF.
        ecnt = 4'd5;
        flush = 1; freeze = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ecnt != 4'hF) ecnt = ecnt + 4'd1;
            chk($sformatf("sat%0d.cnt", i), {28'd0, bubble_cnt},
                {28'd0, ecnt});
        end
        chk("sat.final", {28'd0, bubble_cnt}, 32'hF);

        // Source indices, and a plain load leaves the saturated count.
        flush = 0; valid_in = 1; src1_in = 4'd3; src2_in = 4'd7;
        step();
`ifdef ID_EXE_FORWARDING_EN
        chk("src1", {28'd0, src1_out}, 32'd3);
        chk("src2", {28'd0, src2_out}, 32'd7);
`else
        chk("src1", {28'd0, src1_out}, 32'd0);
        chk("src2", {28'd0, src2_out}, 32'd0);
`endif
        chk("post_sat.cnt", {28'd0, bubble_cnt}, 32'hF);
        chk("post_sat.valid", {31'd0, valid_out}, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
